// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex seven-segment driver with dead-time, per-digit blanking and frame-coherent updates.
// Optional leading-zero suppression is built when SEVEN_SEG_LZ_SUPPRESS_EN is defined.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int DEAD_CYCLES  = 1,
    parameter int COMMON_ANODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0]            SEG_OFF = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (COMMON_ANODE != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        // Bit order is {g, f, e, d, c, b, a}, active-high.
        case (nib)
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pending_valid_q, pending_valid_d;
    logic [4*NUM_DIGITS-1:0] display_q, display_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_start_q, frame_start_d;

    logic                    slot_end;
    logic                    frame_end;
    logic                    lz_dark;
    logic                    dark;
    logic [3:0]              nibble;
    logic [6:0]              seg_raw;
    logic [NUM_DIGITS-1:0]   an_raw;

    // Scan counters and the pending/display double buffer.
    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        slot_end        = (cnt_q == CNT_W'(CLK_DIV - 1));
        frame_end       = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d           = slot_end ? '0 : cnt_q + 1'b1;
        idx_d           = idx_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        display_d       = display_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        if (frame_end) begin
            // A load landing exactly on the boundary bypasses pending so it is not lost.
            if (load) begin
                display_d = value;
            end else if (pending_valid_q) begin
                display_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end else if (load) begin
            pending_d       = value;
            pending_valid_d = 1'b1;
        end
    end

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
    logic hi_zero;

    always_comb begin
        hi_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx_q) && display_q[4*k +: 4] != 4'h0) begin
                hi_zero = 1'b0;
            end
        end
        lz_dark = (idx_q != '0) && hi_zero;
    end
`else
    assign lz_dark = 1'b0;
`endif

    // Output decode from the current (cnt, idx); registered below, so it appears one cycle later.
    always_comb begin
        nibble        = display_q[4*idx_q +: 4];
        dark          = (cnt_q < CNT_W'(DEAD_CYCLES)) || blank_mask[idx_q] || lz_dark;
        seg_raw       = dark ? 7'h00 : glyph(nibble);
        an_raw        = dark ? '0 : (NUM_DIGITS'(1) << idx_q);
        seg_d         = (COMMON_ANODE != 0) ? ~seg_raw : seg_raw;
        an_d          = (COMMON_ANODE != 0) ? ~an_raw : an_raw;
        frame_start_d = (cnt_q == '0) && (idx_q == '0);
    end

    // NOTE: reset is synchronous and sampled only on the clock edge; all state uses non-blocking assignment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q           <= '0;
            idx_q           <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            display_q       <= '0;
            seg_q           <= SEG_OFF;
            an_q            <= AN_OFF;
            frame_start_q   <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            display_q       <= display_d;
            seg_q           <= seg_d;
            an_q            <= an_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule
